// File: rtl/fsm1_responder_pkg.sv
// Shared definitions for the FSM1 responder: state encoding, BCD digit width
// and the largest legal BCD digit.
package fsm1_responder_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CAP1 = 3'd1,
    ACK1 = 3'd2,
    CAP2 = 3'd3,
    ACK2 = 3'd4,
    CAP3 = 3'd5,
    ACK3 = 3'd6,
    DONE = 3'd7
  } state_t;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] DIGIT_MAX = 4'd9;

endpackage

// File: rtl/fsm1_responder_bcd2_capture.sv
// Two-digit BCD field capture shared by all three fields.
// The tens digit is held in a register; the units digit is the live key code
// on the completing strobe, so value/done_ok/done_err are valid only in that
// cycle and the caller registers them on the same edge.
module bcd2_capture
  import fsm1_responder_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic               tecla,
  input  logic [BCD_W-1:0]   dato,
  input  logic               borrar,
  input  logic [6:0]         max_val,
  output logic               accept,
  output logic               done_ok,
  output logic               done_err,
  output logic [2*BCD_W-1:0] value
);

  logic [BCD_W-1:0] tens_q;
  logic             have_tens_q;
  logic [6:0]       bin;

  // Digit acceptance and range check of the completed two-digit value
  always_comb begin
    accept   = enable && tecla && !borrar && (dato <= DIGIT_MAX);
    bin      = 7'(tens_q) * 7'd10 + 7'(dato);
    done_ok  = accept && have_tens_q && (bin <= max_val);
    done_err = accept && have_tens_q && (bin > max_val);
    value    = {tens_q, dato};
  end

  // Tens digit and digit-count register; cleared after every completed entry
  always_ff @(posedge clk) begin
    if (reset || clear || (enable && borrar)) begin
      tens_q      <= '0;
      have_tens_q <= 1'b0;
    end else if (accept) begin
      if (!have_tens_q) begin
        tens_q      <= dato;
        have_tens_q <= 1'b1;
      end else begin
        tens_q      <= '0;
        have_tens_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fsm1_responder.sv
// Responder end of the FSM1 stage-sequencing handshake: captures three BCD
// fields, raises a held valid per field until the sequencer acknowledges it,
// then holds terminar until listo.
// Optional build macro FSM1_RESPONDER_TIMEOUT_EN adds an idle-key abort
// from the capture states after TIMEOUT_CYCLES cycles.
module fsm1_responder
  import fsm1_responder_pkg::*;
#(
  parameter int unsigned MAX1 = 23,
  parameter int unsigned MAX2 = 59,
  parameter int unsigned MAX3 = 59
`ifdef FSM1_RESPONDER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       tecla,
  input  logic [3:0] dato,
  input  logic       borrar,
  input  logic       pasar1,
  input  logic       pasar2,
  input  logic       pasar3,
  input  logic       listo,
  output logic       iniciar,
  output logic       validat,
  output logic       validap,
  output logic       validab,
  output logic       terminar,
  output logic [7:0] campo1,
  output logic [7:0] campo2,
  output logic [7:0] campo3,
  output logic       error
);

  state_t     state_q, state_d;
  logic       in_cap;
  logic [6:0] max_sel;
  logic       cap_accept, cap_ok, cap_err;
  logic [7:0] cap_value;
  logic       timeout;

  logic       iniciar_d, validat_d, validap_d, validab_d, terminar_d, error_d;
  logic [7:0] campo1_d, campo2_d, campo3_d;

  // Capture-state decode and per-field upper bound
  always_comb begin
    in_cap = (state_q == CAP1) || (state_q == CAP2) || (state_q == CAP3);
    case (state_q)
      CAP1:    max_sel = 7'(MAX1);
      CAP2:    max_sel = 7'(MAX2);
      default: max_sel = 7'(MAX3);
    endcase
  end

  bcd2_capture u_capture (
    .clk      (clk),
    .reset    (reset),
    .enable   (in_cap),
    .clear    (timeout),
    .tecla    (tecla),
    .dato     (dato),
    .borrar   (borrar),
    .max_val  (max_sel),
    .accept   (cap_accept),
    .done_ok  (cap_ok),
    .done_err (cap_err),
    .value    (cap_value)
  );

`ifdef FSM1_RESPONDER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] idle_q;

  // Idle-key counter: runs only while capturing, restarts on keys and state changes
  always_ff @(posedge clk) begin
    if (reset || !in_cap || cap_accept || (state_d != state_q)) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + CNT_W'(1);
    end
  end

  // Abort request once the idle budget is used up
  always_comb begin
    timeout = in_cap && !cap_accept && (idle_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end
`else
  // Capture states wait indefinitely in this build
  always_comb begin
    timeout = 1'b0;
  end
`endif

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_d    = state_q;
    iniciar_d  = 1'b0;
    validat_d  = 1'b0;
    validap_d  = 1'b0;
    validab_d  = 1'b0;
    terminar_d = 1'b0;
    error_d    = 1'b0;
    campo1_d   = campo1;
    campo2_d   = campo2;
    campo3_d   = campo3;
    case (state_q)
      IDLE: begin
        if (start) begin
          iniciar_d = 1'b1;
          state_d   = CAP1;
        end
      end
      CAP1: begin
        if (timeout) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else if (cap_ok) begin
          campo1_d  = cap_value;
          validat_d = 1'b1;
          state_d   = ACK1;
        end else if (cap_err) begin
          error_d = 1'b1;
        end
      end
      ACK1: begin
        if (pasar1) state_d = CAP2;
        else        validat_d = 1'b1;
      end
      CAP2: begin
        if (timeout) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else if (cap_ok) begin
          campo2_d  = cap_value;
          validap_d = 1'b1;
          state_d   = ACK2;
        end else if (cap_err) begin
          error_d = 1'b1;
        end
      end
      ACK2: begin
        if (pasar2) state_d = CAP3;
        else        validap_d = 1'b1;
      end
      CAP3: begin
        if (timeout) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else if (cap_ok) begin
          campo3_d  = cap_value;
          validab_d = 1'b1;
          state_d   = ACK3;
        end else if (cap_err) begin
          error_d = 1'b1;
        end
      end
      ACK3: begin
        if (pasar3) begin
          state_d    = DONE;
          terminar_d = 1'b1;
        end else begin
          validab_d = 1'b1;
        end
      end
      DONE: begin
        if (listo) state_d = IDLE;
        else       terminar_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      iniciar  <= 1'b0;
      validat  <= 1'b0;
      validap  <= 1'b0;
      validab  <= 1'b0;
      terminar <= 1'b0;
      error    <= 1'b0;
      campo1   <= '0;
      campo2   <= '0;
      campo3   <= '0;
    end else begin
      state_q  <= state_d;
      iniciar  <= iniciar_d;
      validat  <= validat_d;
      validap  <= validap_d;
      validab  <= validab_d;
      terminar <= terminar_d;
      error    <= error_d;
      campo1   <= campo1_d;
      campo2   <= campo2_d;
      campo3   <= campo3_d;
    end
  end

endmodule

// File: tb/tb_fsm1_responder.sv
// Self-checking bench for fsm1_responder: directed handshake scenarios then
// randomized traffic, all checked every cycle against a field-level model.
module tb_fsm1_responder;

`ifdef FSM1_RESPONDER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO_CYC = 16;

  localparam int M_IDLE = 0;
  localparam int M_CAP  = 1;
  localparam int M_ACK  = 2;
  localparam int M_DONE = 3;

  logic       clk = 1'b0;
  logic       reset, start, tecla, borrar, pasar1, pasar2, pasar3, listo;
  logic [3:0] dato;
  logic       iniciar, validat, validap, validab, terminar, error;
  logic [7:0] campo1, campo2, campo3;

  int tests = 0;
  int fails = 0;

  int         m_mode, m_field, m_idle;
  int         m_digs[$];
  logic [7:0] m_campo [1:3];
  logic       m_ini, m_err;

  always #5 clk = ~clk;

  fsm1_responder #(
    .MAX1(23),
    .MAX2(59),
    .MAX3(59)
`ifdef FSM1_RESPONDER_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(TO_CYC)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start(start), .tecla(tecla), .dato(dato),
    .borrar(borrar), .pasar1(pasar1), .pasar2(pasar2), .pasar3(pasar3),
    .listo(listo), .iniciar(iniciar), .validat(validat), .validap(validap),
    .validab(validab), .terminar(terminar), .campo1(campo1), .campo2(campo2),
    .campo3(campo3), .error(error)
  );

  function automatic int fmax(input int f);
    return (f == 1) ? 23 : 59;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_field = 1;
    m_idle = 0;
    m_digs.delete();
    for (int i = 1; i <= 3; i++) m_campo[i] = 8'h00;
    m_ini = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_update();
    int v;
    logic [3:0] t, u;
    logic ack;
    m_ini = 1'b0;
    m_err = 1'b0;
    if (reset) begin
      model_reset();
      return;
    end
    case (m_mode)
      M_IDLE: if (start) begin
        m_ini = 1'b1; m_mode = M_CAP; m_field = 1; m_idle = 0;
      end
      M_CAP: begin
        if (tecla && !borrar && dato <= 4'd9) begin
          m_idle = 0;
          m_digs.push_back(int'(dato));
          if (m_digs.size() == 2) begin
            v = m_digs[0] * 10 + m_digs[1];
            t = 4'(m_digs[0]);
            u = 4'(m_digs[1]);
            if (v <= fmax(m_field)) begin
              m_campo[m_field] = {t, u};
              m_mode = M_ACK;
            end else begin
              m_err = 1'b1;
            end
            m_digs.delete();
          end
        end else begin
          if (borrar) m_digs.delete();
          if (TO_EN && m_idle == TO_CYC - 1) begin
            m_err = 1'b1; m_digs.delete(); m_mode = M_IDLE;
          end else begin
            m_idle++;
          end
        end
      end
      M_ACK: begin
        ack = (m_field == 1) ? pasar1 : (m_field == 2) ? pasar2 : pasar3;
        if (ack) begin
          if (m_field == 3) m_mode = M_DONE;
          else begin m_field++; m_mode = M_CAP; m_idle = 0; end
        end
      end
      default: if (listo) m_mode = M_IDLE;
    endcase
  endtask

  task automatic check_all();
    chk("iniciar",  iniciar,  m_ini);
    chk("error",    error,    m_err);
    chk("validat",  validat,  (m_mode == M_ACK && m_field == 1));
    chk("validap",  validap,  (m_mode == M_ACK && m_field == 2));
    chk("validab",  validab,  (m_mode == M_ACK && m_field == 3));
    chk("terminar", terminar, (m_mode == M_DONE));
    chk("campo1",   campo1,   m_campo[1]);
    chk("campo2",   campo2,   m_campo[2]);
    chk("campo3",   campo3,   m_campo[3]);
  endtask

  task automatic clear_inputs();
    start = 0; tecla = 0; dato = 4'd0; borrar = 0;
    pasar1 = 0; pasar2 = 0; pasar3 = 0; listo = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
    clear_inputs();
  endtask

  task automatic key(input logic [3:0] d);
    tecla = 1'b1; dato = d; step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    chk("rst_campo1", campo1, 8'h00);
    chk("rst_terminar", terminar, 1'b0);

    // Keys before start are ignored
    key(4'd1); key(4'd2);
    chk("idle_keys_validat", validat, 1'b0);

    start = 1'b1; step();
    chk("iniciar_pulse", iniciar, 1'b1);
    step();
    chk("iniciar_one_cycle", iniciar, 1'b0);

    // Field 1 with an ignored non-digit in between
    key(4'd1); key(4'hB); key(4'd5);
    chk("f1_valid", validat, 1'b1);
    chk("f1_value", campo1, 8'h15);

    // Foreign acknowledge plus keys in ACK1 change nothing
    pasar2 = 1'b1; tecla = 1'b1; dato = 4'd7; borrar = 1'b1; step();
    chk("ack1_hold", validat, 1'b1);
    pasar1 = 1'b1; step();
    chk("ack1_release", validat, 1'b0);

    // borrar with tecla after one digit wins; next two keys form the field
    key(4'd8);
    borrar = 1'b1; tecla = 1'b1; dato = 4'd3; step();
    key(4'd4); key(4'd2);
    chk("f2_value", campo2, 8'h42);
    chk("f2_valid", validap, 1'b1);
    pasar2 = 1'b1; step();

    key(4'd0); key(4'd9);
    chk("f3_value", campo3, 8'h09);
    pasar3 = 1'b1; step();
    chk("done_terminar", terminar, 1'b1);
    idle(20);
    chk("terminar_held", terminar, 1'b1);
    listo = 1'b1; step();
    chk("terminar_drop", terminar, 1'b0);

    // Out-of-range then in-range field 1
    start = 1'b1; step();
    key(4'd2); key(4'd4);
    chk("range_err", error, 1'b1);
    chk("range_novalid", validat, 1'b0);
    chk("range_keep", campo1, 8'h15);
    step();
    chk("err_one_cycle", error, 1'b0);
    key(4'd2); key(4'd3);
    chk("max1_value", campo1, 8'h23);
    pasar1 = 1'b1; step();
    key(4'd1); key(4'd0);
    chk("ack2_valid", validap, 1'b1);

    // Reset in ACK2 aborts and clears the fields
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_validap", validap, 1'b0);
    chk("rst_clr_campo1", campo1, 8'h00);
    chk("rst_clr_campo2", campo2, 8'h00);
    key(4'd1); key(4'd2);
    chk("rst_needs_start", validat, 1'b0);

    // Idle-key abort (or indefinite wait) in CAP1
    start = 1'b1; step();
    key(4'd1);
    idle(TO_CYC - 1);
    chk("no_early_timeout", error, 1'b0);
    idle(1);
`ifdef FSM1_RESPONDER_TIMEOUT_EN
    chk("timeout_err", error, 1'b1);
    key(4'd2);
    chk("timeout_to_idle", validat, 1'b0);
`else
    chk("no_timeout", error, 1'b0);
    key(4'd2);
    chk("still_cap1", validat, 1'b1);
    chk("still_cap1_val", campo1, 8'h12);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      reset  = ($urandom_range(0, 399) == 0);
      start  = ($urandom_range(0, 7) == 0);
      tecla  = ($urandom_range(0, 1) == 1);
      dato   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                           : 4'($urandom_range(0, 6));
      borrar = ($urandom_range(0, 15) == 0);
      pasar1 = ($urandom_range(0, 3) == 0);
      pasar2 = ($urandom_range(0, 3) == 0);
      pasar3 = ($urandom_range(0, 3) == 0);
      listo  = ($urandom_range(0, 3) == 0);
      step();
      reset = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
